debug_unit_ctrl: RTL and testbench

- Host-side controller for the pipeline's debug unit port.
- Consumes a byte stream from the UART receiver and decodes host commands: load program, run, step, reset PC.
- Drives the pipeline's dunit inputs: clock enable, PC reset, instruction-memory write, address and data.
- After every run or step, serialises the register file, the four pipeline latches and a data-memory window back to the UART transmitter.

---
 rtl/debug_unit_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_debug_unit_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: host command decoder, program loader and state dumper
// for the pipeline debug unit, bridging the UART byte stream to the dunit.
module debug_unit_ctrl #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_IFID = 64,
  parameter int NB_IDEX = 144,
  parameter int NB_EXM  = 88,
  parameter int NB_MWB  = 80,
  parameter int N_REGS  = 32,
  parameter int N_MEMW  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data_if,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  input  logic [NB_IFID-1:0] i_IF_ID,
  input  logic [NB_IDEX-1:0] i_ID_EX,
  input  logic [NB_EXM-1:0]  i_EX_M,
  input  logic [NB_MWB-1:0]  i_M_WB,
  input  logic               i_halt,
  output logic               o_busy
);

  localparam int BPW = NB_REG / NB_BYTE;
  localparam int BW  = $clog2(BPW);
  localparam int LW  = NB_IFID + NB_IDEX + NB_EXM + NB_MWB;
  localparam int LB  = LW / NB_BYTE;
  localparam int LCW = $clog2(LB);
  localparam int CW  = NB_BYTE + 1;
  localparam int IW  = 16;

  localparam logic [NB_BYTE-1:0] C_L   = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] C_C   = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] C_S   = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] C_R   = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] C_K   = NB_BYTE'(8'h4B);
  localparam logic [NB_BYTE-1:0] C_ERR = NB_BYTE'(8'hEE);
  localparam logic [NB_BYTE-1:0] C_H   = NB_BYTE'(8'h48);

  typedef enum logic [3:0] {
    S_IDLE, S_LCNT, S_LBYTE, S_LWRITE,
    S_RUN, S_STEP, S_STEP_HI, S_RSTPC, S_REPLY,
    S_DENTER, S_DADDR, S_DSAMPLE, S_DWORD, S_DLATCH, S_DTRAIL
  } state_t;

  state_t             r_state, w_state;
  logic [NB_BYTE-1:0] r_tx_data, w_tx_data;
  logic               r_tx_valid, w_tx_valid;
  logic               r_clk_en, w_clk_en;
  logic               r_reset_pc, w_reset_pc;
  logic               r_w_mem, w_w_mem;
  logic [NB_REG-1:0]  r_addr, w_addr;
  logic [NB_REG-1:0]  r_data_if, w_data_if;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [CW-1:0]      r_k, w_k;
  logic [BW-1:0]      r_bcnt, w_bcnt;
  logic [IW-1:0]      r_idx, w_idx;
  logic               r_mem_phase, w_mem_phase;
  logic [NB_REG-1:0]  r_word, w_word;
  logic [LW-1:0]      r_latch, w_latch;
  logic [LCW-1:0]     r_lcnt, w_lcnt;

  logic               w_tx_done;
  logic               w_last_idx;
  logic [IW-1:0]      w_idx_inc;

  assign w_tx_done  = r_tx_valid & i_tx_ready;
  assign w_idx_inc  = r_idx + IW'(1);
  assign w_last_idx = r_mem_phase ? (r_idx == IW'(N_MEMW - 1))
                                  : (r_idx == IW'(N_REGS - 1));

  // State and datapath registers; a reset abandons any load or dump.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_clk_en    <= 1'b0;
      r_reset_pc  <= 1'b0;
      r_w_mem     <= 1'b0;
      r_addr      <= '0;
      r_data_if   <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_bcnt      <= '0;
      r_idx       <= '0;
      r_mem_phase <= 1'b0;
      r_word      <= '0;
      r_latch     <= '0;
      r_lcnt      <= '0;
    end else begin
      r_state     <= w_state;
      r_tx_data   <= w_tx_data;
      r_tx_valid  <= w_tx_valid;
      r_clk_en    <= w_clk_en;
      r_reset_pc  <= w_reset_pc;
      r_w_mem     <= w_w_mem;
      r_addr      <= w_addr;
      r_data_if   <= w_data_if;
      r_cnt       <= w_cnt;
      r_k         <= w_k;
      r_bcnt      <= w_bcnt;
      r_idx       <= w_idx;
      r_mem_phase <= w_mem_phase;
      r_word      <= w_word;
      r_latch     <= w_latch;
      r_lcnt      <= w_lcnt;
    end
  end

  // Next-state and next-value logic for commands, load and dump.
  always_comb begin
    w_state     = r_state;
    w_tx_data   = r_tx_data;
    w_tx_valid  = r_tx_valid;
    w_clk_en    = r_clk_en;
    w_reset_pc  = r_reset_pc;
    w_w_mem     = r_w_mem;
    w_addr      = r_addr;
    w_data_if   = r_data_if;
    w_cnt       = r_cnt;
    w_k         = r_k;
    w_bcnt      = r_bcnt;
    w_idx       = r_idx;
    w_mem_phase = r_mem_phase;
    w_word      = r_word;
    w_latch     = r_latch;
    w_lcnt      = r_lcnt;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            C_L: begin
              w_state    = S_LCNT;
              w_reset_pc = 1'b1;
            end
            C_C: w_state = S_RUN;
            C_S: w_state = S_STEP;
            C_R: begin
              w_state    = S_RSTPC;
              w_reset_pc = 1'b1;
            end
            default: begin
              w_tx_data  = C_ERR;
              w_tx_valid = 1'b1;
              w_state    = S_REPLY;
            end
          endcase
        end
      end
      S_LCNT: begin
        if (i_rx_valid) begin
          w_cnt  = (i_rx_data == '0) ? {1'b1, {NB_BYTE{1'b0}}}
                                     : {1'b0, i_rx_data};
          w_k    = '0;
          w_bcnt = '0;
          w_state = S_LBYTE;
        end
      end
      S_LBYTE: begin
        if (i_rx_valid) begin
          w_data_if = {r_data_if[NB_REG-NB_BYTE-1:0], i_rx_data};
          w_bcnt    = r_bcnt + BW'(1);
          if (r_bcnt == BW'(BPW - 1)) begin
            w_w_mem = 1'b1;
            w_addr  = NB_REG'({r_k, 2'b00});
            w_state = S_LWRITE;
          end
        end
      end
      S_LWRITE: begin
        w_w_mem = 1'b0;
        if (r_k == r_cnt - CW'(1)) begin
          w_reset_pc = 1'b0;
          w_tx_data  = C_K;
          w_tx_valid = 1'b1;
          w_state    = S_REPLY;
        end else begin
          w_k     = r_k + CW'(1);
          w_state = S_LBYTE;
        end
      end
      S_RUN: begin
        if (i_halt) begin
          w_clk_en = 1'b0;
          w_state  = S_DENTER;
        end else begin
          w_clk_en = 1'b1;
        end
      end
      S_STEP: begin
        if (i_halt) begin
          w_state = S_DENTER;
        end else begin
          w_clk_en = 1'b1;
          w_state  = S_STEP_HI;
        end
      end
      S_STEP_HI: begin
        w_clk_en = 1'b0;
        w_state  = S_DENTER;
      end
      S_RSTPC: begin
        w_reset_pc = 1'b0;
        w_tx_data  = C_K;
        w_tx_valid = 1'b1;
        w_state    = S_REPLY;
      end
      S_REPLY: begin
        if (w_tx_done) begin
          w_tx_valid = 1'b0;
          w_state    = S_IDLE;
        end
      end
      S_DENTER: begin
        w_latch     = {i_IF_ID, i_ID_EX, i_EX_M, i_M_WB};
        w_idx       = '0;
        w_mem_phase = 1'b0;
        w_addr      = '0;
        w_state     = S_DADDR;
      end
      S_DADDR: w_state = S_DSAMPLE;
      S_DSAMPLE: begin
        w_word  = r_mem_phase ? i_dunit_mem_data : i_dunit_reg;
        w_bcnt  = '0;
        w_state = S_DWORD;
      end
      S_DWORD: begin
        if (!r_tx_valid) begin
          w_tx_valid = 1'b1;
          w_tx_data  = r_word[NB_REG-1 -: NB_BYTE];
        end else if (i_tx_ready) begin
          w_tx_valid = 1'b0;
          w_word     = r_word << NB_BYTE;
          w_bcnt     = r_bcnt + BW'(1);
          if (r_bcnt == BW'(BPW - 1)) begin
            if (!w_last_idx) begin
              w_idx   = w_idx_inc;
              w_addr  = r_mem_phase ? NB_REG'({w_idx_inc, 2'b00})
                                    : NB_REG'(w_idx_inc);
              w_state = S_DADDR;
            end else if (r_mem_phase) begin
              w_state = S_DTRAIL;
            end else begin
              w_lcnt  = '0;
              w_state = S_DLATCH;
            end
          end
        end
      end
      S_DLATCH: begin
        if (!r_tx_valid) begin
          w_tx_valid = 1'b1;
          w_tx_data  = r_latch[LW-1 -: NB_BYTE];
        end else if (i_tx_ready) begin
          w_tx_valid = 1'b0;
          w_latch    = r_latch << NB_BYTE;
          w_lcnt     = r_lcnt + LCW'(1);
          if (r_lcnt == LCW'(LB - 1)) begin
            w_mem_phase = 1'b1;
            w_idx       = '0;
            w_addr      = '0;
            w_state     = S_DADDR;
          end
        end
      end
      S_DTRAIL: begin
        if (!r_tx_valid) begin
          w_tx_valid = 1'b1;
          w_tx_data  = i_halt ? C_H : C_S;
        end else if (i_tx_ready) begin
          w_tx_valid = 1'b0;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign o_tx_data        = r_tx_data;
  assign o_tx_valid       = r_tx_valid;
  assign o_dunit_clk_en   = r_clk_en;
  assign o_dunit_reset_pc = r_reset_pc;
  assign o_dunit_w_mem    = r_w_mem;
  assign o_dunit_addr     = r_addr;
  assign o_dunit_data_if  = r_data_if;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// tb_debug_unit_ctrl: directed bench with a byte-stream model of the
// host protocol; a monitor checks every tx byte and imem write.
module tb_debug_unit_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         clk_en, reset_pc, w_mem;
  logic [31:0]  addr, data_if, dreg, dmem;
  logic [63:0]  if_id;
  logic [143:0] id_ex;
  logic [87:0]  ex_m;
  logic [79:0]  m_wb;
  logic         halt;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int rpc_cnt = 0;
  int w_cnt   = 0;
  logic [31:0] last_waddr = '0;
  bit   bp_mode = 1'b0;
  int   bp_ph = 0;

  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [63:0] exp_w[$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_wmem  = 1'b0;

  always #5 clk = ~clk;

  assign dreg = 32'h1000_0000 + addr;
  assign dmem = 32'hA500_0000 | addr;

  debug_unit_ctrl dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (tx_ready),
    .o_dunit_clk_en   (clk_en),
    .o_dunit_reset_pc (reset_pc),
    .o_dunit_w_mem    (w_mem),
    .o_dunit_addr     (addr),
    .o_dunit_data_if  (data_if),
    .i_dunit_reg      (dreg),
    .i_dunit_mem_data (dmem),
    .i_IF_ID          (if_id),
    .i_ID_EX          (id_ex),
    .i_EX_M           (ex_m),
    .i_M_WB           (m_wb),
    .i_halt           (halt),
    .o_busy           (busy)
  );

  // Transmitter ready: always on, or 3 on / 3 off when throttling.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      bp_ph = (bp_ph + 1) % 6;
      tx_ready = (bp_ph < 3);
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Monitor: tx bytes, hold rule, imem writes, enable counts.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_wmem  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        n_tests++;
        if (!(tx_valid && tx_data == prev_data)) begin
          n_fail++;
          $display("FAIL tx_hold: got valid=%0d data=%02h required valid=1 data=%02h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid && tx_ready) begin
        n_tests++;
        tx_log.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got %02h required no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL tx_byte[%0d]: got %02h required %02h",
                     tx_log.size() - 1, tx_data, e);
          end
        end
      end
      if (w_mem) begin
        n_tests++;
        w_cnt++;
        last_waddr = addr;
        if (exp_w.size() == 0) begin
          n_fail++;
          $display("FAIL wmem_unexpected: got addr=%08h data=%08h", addr, data_if);
        end else begin
          logic [63:0] e;
          e = exp_w.pop_front();
          if ({addr, data_if} !== e || !reset_pc || clk_en || prev_wmem) begin
            n_fail++;
            $display("FAIL wmem: got addr=%08h data=%08h rpc=%0d en=%0d prev=%0d required %016h rpc=1 en=0 prev=0",
                     addr, data_if, reset_pc, clk_en, prev_wmem, e);
          end
        end
      end
      if (clk_en) en_cnt++;
      if (reset_pc) rpc_cnt++;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_wmem  = w_mem;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check(nm, {tx_valid, tx_data, clk_en, reset_pc, w_mem, busy,
               addr ^ data_if, 22'h0}, 64'h0);
    check({nm, "_addr"}, {addr, data_if}, 64'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick;
    rx_data  = b;
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0) && n < budget) begin
      tick;
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d required idle",
               nm, busy, exp_tx.size());
    end
  endtask

  function automatic logic [31:0] reg_val(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] mem_val(input int j);
    return 32'hA500_0000 + 32'(4 * j);
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic h);
    for (int i = 0; i < 32; i++) push_word(reg_val(i));
    for (int b = 7; b >= 0; b--)  exp_tx.push_back(if_id[8*b +: 8]);
    for (int b = 17; b >= 0; b--) exp_tx.push_back(id_ex[8*b +: 8]);
    for (int b = 10; b >= 0; b--) exp_tx.push_back(ex_m[8*b +: 8]);
    for (int b = 9; b >= 0; b--)  exp_tx.push_back(m_wb[8*b +: 8]);
    for (int j = 0; j < 32; j++) push_word(mem_val(j));
    exp_tx.push_back(h ? 8'h48 : 8'h53);
  endtask

  initial begin
    int base;
    int n;
    logic [63:0] first8;
    logic [7:0]  lb;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    halt     = 1'b0;
    if_id = 64'h0123_4567_89AB_CDEF;
    id_ex = {16'hC0DE, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    ex_m  = {24'hABCDEF, 64'h0F1E_2D3C_4B5A_6978};
    m_wb  = {16'hBEEF, 64'hFEDC_BA98_7654_3210};
    repeat (3) tick;
    check_reset("reset_state");
    rst = 1'b0;
    tick;

    exp_tx.push_back(8'h4B);
    rpc_cnt = 0;
    send_byte(8'h52);
    wait_done("cmd_R", 100);
    check("cmd_R_rpc_pulse", 64'(rpc_cnt), 64'd1);

    exp_w.push_back({32'h0, 32'h2006_000B});
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h0B);
    send_byte(8'h08);
    tick;
    tick;
    rst = 1'b1;
    #1;
    check_reset("reset_midload");
    tick;
    rst = 1'b0;
    tick;
    check("midload_w0_seen", 64'(exp_w.size()), 64'd0);
    exp_tx.push_back(8'h4B);
    send_byte(8'h52);
    wait_done("after_reset_R", 100);

    exp_w.push_back({32'h0, 32'h2006_000B});
    exp_w.push_back({32'h4, 32'h0800_0010});
    exp_tx.push_back(8'h4B);
    en_cnt = 0;
    w_cnt  = 0;
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h0B);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    wait_done("load2", 200);
    check("load2_writes", 64'(w_cnt), 64'd2);
    check("load2_clk_en", 64'(en_cnt), 64'd0);
    check("load2_rpc_low", 64'(reset_pc), 64'd0);

    en_cnt = 0;
    base = tx_log.size();
    push_dump(1'b0);
    send_byte(8'h53);
    wait_done("step", 5000);
    check("step_clk_en", 64'(en_cnt), 64'd1);
    check("step_count", 64'(tx_log.size() - base), 64'd304);
    first8 = '0;
    for (int i = 0; i < 8; i++) first8 = {first8[55:0], tx_log[base + i]};
    check("step_first8", first8, 64'h1000_0000_1000_0001);
    lb = tx_log[tx_log.size() - 1];
    check("step_trailer", 64'(lb), 64'h53);

    en_cnt = 0;
    base = tx_log.size();
    push_dump(1'b1);
    send_byte(8'h43);
    repeat (7) tick;
    halt = 1'b1;
    wait_done("run", 5000);
    check("run_clk_en", 64'(en_cnt), 64'd7);
    lb = tx_log[tx_log.size() - 1];
    check("run_trailer", 64'(lb), 64'h48);

    en_cnt = 0;
    base = tx_log.size();
    push_dump(1'b1);
    send_byte(8'h43);
    wait_done("run_halted", 5000);
    check("run_halted_clk_en", 64'(en_cnt), 64'd0);
    check("run_halted_count", 64'(tx_log.size() - base), 64'd304);

    en_cnt = 0;
    base = tx_log.size();
    push_dump(1'b1);
    send_byte(8'h53);
    wait_done("step_halted", 5000);
    check("step_halted_clk_en", 64'(en_cnt), 64'd0);
    halt = 1'b0;

    en_cnt = 0;
    base = tx_log.size();
    bp_mode = 1'b1;
    push_dump(1'b0);
    send_byte(8'h53);
    n = 0;
    while (tx_log.size() < base + 40 && n < 2000) begin
      tick;
      n++;
    end
    check("bp_progress", 64'(n < 2000), 64'd1);
    if_id = ~if_id;
    id_ex = ~id_ex;
    ex_m  = ~ex_m;
    m_wb  = ~m_wb;
    wait_done("bp_step", 8000);
    bp_mode = 1'b0;
    check("bp_count", 64'(tx_log.size() - base), 64'd304);
    check("bp_clk_en", 64'(en_cnt), 64'd1);

    base = tx_log.size();
    exp_tx.push_back(8'hEE);
    send_byte(8'h7A);
    wait_done("bad_cmd", 100);
    check("bad_cmd_count", 64'(tx_log.size() - base), 64'd1);

    w_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w = {w[23:0], 8'(4 * k + i)};
      exp_w.push_back({32'(4 * k), w});
    end
    exp_tx.push_back(8'h4B);
    send_byte(8'h4C);
    send_byte(8'h00);
    for (int i = 0; i < 1024; i++) send_byte(8'(i));
    wait_done("load256", 200);
    check("load256_writes", 64'(w_cnt), 64'd256);
    check("load256_last_addr", 64'(last_waddr), 64'h3FC);
    check("load256_wq_empty", 64'(exp_w.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
